// File: rtl/hazard_unit.sv
// Hazard and forwarding controller: shift-register scoreboard of in-flight writers,
// youngest-wins bypass select, load-use stall and multi-cycle kill window.
module hazard_unit #(
  parameter int DEPTH       = 2,
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 2,
  parameter int KILL_CYCLES = 1,
  parameter int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] rd,
  input  logic              rd_we,
  input  logic              is_load,
  input  logic              issue_valid,
  input  logic              flush_req,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall,
  output logic              inst_kill,
  output logic [15:0]       stall_cycles
);

  localparam int                KW           = 2;
  localparam logic [KW-1:0]     KILL_RELOAD  = KW'(KILL_CYCLES - 1);
  localparam logic [KW-1:0]     KILL_ONE     = KW'(1);
  localparam logic [SEL_W-1:0]  LOAD_LAT_SEL = SEL_W'(LOAD_LAT);

  // Scoreboard slots: index k is the writer k stages past decode.
  logic              vld_p [1:DEPTH];
  logic [REG_AW-1:0] rd_p  [1:DEPTH];
  logic              ld_p  [1:DEPTH];

  logic [KW-1:0]     kill_cnt;
  logic              ld_a;
  logic              ld_b;
  logic              hazard;
  logic              slot1_vld;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Descending scan so the youngest matching slot is the one left standing.
  always_comb begin
    fwd_sel_a = '0;
    ld_a      = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld_p[k] && (rd_p[k] == rs1) && (rs1 != '0) && rs1_used) begin
        fwd_sel_a = SEL_W'(k);
        ld_a      = ld_p[k];
      end
    end
  end

  always_comb begin
    fwd_sel_b = '0;
    ld_b      = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld_p[k] && (rd_p[k] == rs2) && (rs2 != '0) && rs2_used) begin
        fwd_sel_b = SEL_W'(k);
        ld_b      = ld_p[k];
      end
    end
  end

  // A load is only forwardable once it has reached slot LOAD_LAT.
  always_comb begin
    hazard    = (ld_a && (fwd_sel_a < LOAD_LAT_SEL)) ||
                (ld_b && (fwd_sel_b < LOAD_LAT_SEL));
    inst_kill = flush_req || (kill_cnt != '0);
    stall     = issue_valid && hazard && !inst_kill;
    slot1_vld = issue_valid && rd_we && (rd != '0) && !stall && !inst_kill;
  end

  // Decode -> slot 1, then slot k -> slot k+1 every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        vld_p[k] <= 1'b0;
        rd_p[k]  <= '0;
        ld_p[k]  <= 1'b0;
      end
    end else begin
      vld_p[1] <= slot1_vld;
      rd_p[1]  <= rd;
      ld_p[1]  <= is_load;
      for (int k = 2; k <= DEPTH; k++) begin
        vld_p[k] <= vld_p[k-1];
        rd_p[k]  <= rd_p[k-1];
        ld_p[k]  <= ld_p[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kill_cnt <= '0;
    end else if (flush_req) begin
      kill_cnt <= KILL_RELOAD;
    end else if (kill_cnt != '0) begin
      kill_cnt <= kill_cnt - KILL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall) begin
      stall_cycles <= sat_inc16(stall_cycles);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios, randomized run against an age-ordered
// queue model, and a long stall-counter saturation run on a deep instance.
module tb_hazard_unit;

  localparam int DEPTH = 2;
  localparam int LOAD_LAT = 2;
  localparam int KILL_CYCLES = 2;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1, rs2, rd;
  logic rs1_used, rs2_used, rd_we, is_load, issue_valid, flush_req;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic stall, inst_kill;
  logic [15:0] stall_cycles;

  logic [4:0] s_rs1, s_rs2, s_rd;
  logic s_rs1_used, s_rs2_used, s_rd_we, s_is_load, s_issue_valid, s_flush_req;
  logic [2:0] s_fwd_sel_a, s_fwd_sel_b;
  logic s_stall, s_inst_kill;
  logic [15:0] s_stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_unit #(.DEPTH(DEPTH), .REG_AW(5), .LOAD_LAT(LOAD_LAT), .KILL_CYCLES(KILL_CYCLES), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .rd_we(rd_we), .is_load(is_load), .issue_valid(issue_valid), .flush_req(flush_req),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .inst_kill(inst_kill),
    .stall_cycles(stall_cycles));

  hazard_unit #(.DEPTH(6), .REG_AW(5), .LOAD_LAT(6), .KILL_CYCLES(1), .SEL_W(3)) dut_sat (
    .clk(clk), .reset(reset), .rs1(s_rs1), .rs2(s_rs2), .rs1_used(s_rs1_used), .rs2_used(s_rs2_used),
    .rd(s_rd), .rd_we(s_rd_we), .is_load(s_is_load), .issue_valid(s_issue_valid), .flush_req(s_flush_req),
    .fwd_sel_a(s_fwd_sel_a), .fwd_sel_b(s_fwd_sel_b), .stall(s_stall), .inst_kill(s_inst_kill),
    .stall_cycles(s_stall_cycles));

  // Reference model: writers listed youngest first; kill window as an absolute end cycle.
  typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
  ent_t slots[$];
  int   cyc = 0;
  int   kill_last = -1;
  int   m_cnt = 0;
  int   m_sel_a, m_sel_b;
  bit   m_stall, m_kill;

  typedef struct {
    bit rst, iv; bit [4:0] rs1; bit u1; bit [4:0] rs2; bit u2; bit [4:0] rd;
    bit we, ld, fl; bit [1:0] ea, eb; bit es, ek; bit [15:0] esc;
  } row_t;

  function automatic row_t mk(bit rst, bit iv, int a, bit u1, int b, bit u2, int d, bit we, bit ld,
                              bit fl, int ea, int eb, bit es, bit ek, int esc);
    row_t r;
    r.rst = rst; r.iv = iv; r.rs1 = 5'(a); r.u1 = u1; r.rs2 = 5'(b); r.u2 = u2; r.rd = 5'(d);
    r.we = we; r.ld = ld; r.fl = fl; r.ea = 2'(ea); r.eb = 2'(eb); r.es = es; r.ek = ek; r.esc = 16'(esc);
    return r;
  endfunction

  function automatic void lookup(input logic [4:0] s, input logic used, output int sel, output bit ld);
    sel = 0;
    ld  = 1'b0;
    if (used && s != 5'd0) begin
      for (int k = 0; k < slots.size(); k++) begin
        if (slots[k].v && slots[k].rd == s) begin
          sel = k + 1;
          ld  = slots[k].ld;
          break;
        end
      end
    end
  endfunction

  function automatic void model_eval();
    bit la, lb;
    lookup(rs1, rs1_used, m_sel_a, la);
    lookup(rs2, rs2_used, m_sel_b, lb);
    m_kill  = flush_req || (cyc <= kill_last);
    m_stall = issue_valid && ((la && m_sel_a < LOAD_LAT) || (lb && m_sel_b < LOAD_LAT)) && !m_kill;
  endfunction

  function automatic void model_clear();
    ent_t e;
    e.v = 1'b0; e.rd = 5'd0; e.ld = 1'b0;
    slots.delete();
    repeat (DEPTH) slots.push_back(e);
    kill_last = -1;
    m_cnt = 0;
  endfunction

  task automatic model_tick();
    ent_t e;
    model_eval();
    if (reset) begin
      model_clear();
    end else begin
      e.v  = issue_valid && rd_we && (rd != 5'd0) && !m_stall && !m_kill;
      e.rd = rd;
      e.ld = is_load;
      slots.push_front(e);
      void'(slots.pop_back());
      if (m_stall && m_cnt < 65535) m_cnt++;
      if (flush_req) kill_last = cyc + KILL_CYCLES - 1;
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic apply(input row_t r);
    reset = r.rst; issue_valid = r.iv; rs1 = r.rs1; rs1_used = r.u1; rs2 = r.rs2; rs2_used = r.u2;
    rd = r.rd; rd_we = r.we; is_load = r.ld; flush_req = r.fl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    advance();
    reset = 1'b0;
  endtask

  function automatic string got_str();
    return $sformatf("a=%0d b=%0d stall=%b kill=%b sc=%0d", fwd_sel_a, fwd_sel_b, stall, inst_kill, stall_cycles);
  endfunction

  function automatic string exp_str(input row_t r);
    return $sformatf("a=%0d b=%0d stall=%b kill=%b sc=%0d", r.ea, r.eb, r.es, r.ek, r.esc);
  endfunction

  task automatic test_reset();
    row_t t[4];
    apply(mk(1, 1, 5, 1, 5, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0));
    advance();
    t[0] = mk(1, 1, 5, 1, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    t[1] = mk(1, 1, 5, 1, 5, 1, 5, 1, 1, 1, 0, 0, 0, 1, 0);
    t[2] = mk(0, 1, 5, 1, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    t[3] = mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    foreach (t[i]) begin
      apply(t[i]);
      vectors++;
      if ({fwd_sel_a, fwd_sel_b, stall, inst_kill, stall_cycles} !== {t[i].ea, t[i].eb, t[i].es, t[i].ek, t[i].esc}) begin
        miscompares++;
        $display("FAIL reset row %0d: got %s, expected %s", i, got_str(), exp_str(t[i]));
      end
      advance();
    end
  endtask

  task automatic test_forward();
    row_t t[4];
    do_reset();
    t[0] = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    t[1] = mk(0, 1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 1, 0, 0, 0);
    t[2] = mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    t[3] = mk(0, 1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (t[i]) begin
      apply(t[i]);
      vectors++;
      if ({fwd_sel_a, fwd_sel_b, stall, inst_kill, stall_cycles} !== {t[i].ea, t[i].eb, t[i].es, t[i].ek, t[i].esc}) begin
        miscompares++;
        $display("FAIL forward row %0d: got %s, expected %s", i, got_str(), exp_str(t[i]));
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    row_t t[4];
    do_reset();
    t[0] = mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    t[1] = mk(0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 1, 1, 0, 0);
    t[2] = mk(0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 2, 0, 0, 1);
    t[3] = mk(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    foreach (t[i]) begin
      apply(t[i]);
      vectors++;
      if ({fwd_sel_a, fwd_sel_b, stall, inst_kill, stall_cycles} !== {t[i].ea, t[i].eb, t[i].es, t[i].ek, t[i].esc}) begin
        miscompares++;
        $display("FAIL load_use row %0d: got %s, expected %s", i, got_str(), exp_str(t[i]));
      end
      advance();
    end
  endtask

  task automatic test_youngest_x0();
    row_t t[4];
    do_reset();
    t[0] = mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    t[1] = mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    t[2] = mk(0, 1, 3, 1, 3, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    t[3] = mk(0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    foreach (t[i]) begin
      apply(t[i]);
      vectors++;
      if ({fwd_sel_a, fwd_sel_b, stall, inst_kill, stall_cycles} !== {t[i].ea, t[i].eb, t[i].es, t[i].ek, t[i].esc}) begin
        miscompares++;
        $display("FAIL youngest row %0d: got %s, expected %s", i, got_str(), exp_str(t[i]));
      end
      advance();
    end
  endtask

  task automatic test_kill();
    row_t t[7];
    do_reset();
    t[0] = mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 1, 0);
    t[1] = mk(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1, 0);
    t[2] = mk(0, 1, 9, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t[3] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    t[4] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    t[5] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    t[6] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (t[i]) begin
      apply(t[i]);
      vectors++;
      if ({fwd_sel_a, fwd_sel_b, stall, inst_kill, stall_cycles} !== {t[i].ea, t[i].eb, t[i].es, t[i].ek, t[i].esc}) begin
        miscompares++;
        $display("FAIL kill row %0d: got %s, expected %s", i, got_str(), exp_str(t[i]));
      end
      advance();
    end
  endtask

  task automatic test_stall_vs_kill();
    row_t t[4];
    do_reset();
    t[0] = mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    t[1] = mk(0, 1, 7, 1, 0, 0, 11, 1, 0, 1, 1, 0, 0, 1, 0);
    t[2] = mk(0, 1, 7, 1, 11, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0);
    t[3] = mk(0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (t[i]) begin
      apply(t[i]);
      vectors++;
      if ({fwd_sel_a, fwd_sel_b, stall, inst_kill, stall_cycles} !== {t[i].ea, t[i].eb, t[i].es, t[i].ek, t[i].esc}) begin
        miscompares++;
        $display("FAIL stall_vs_kill row %0d: got %s, expected %s", i, got_str(), exp_str(t[i]));
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    row_t t[4];
    do_reset();
    t[0] = mk(0, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
    t[1] = mk(0, 1, 4, 1, 0, 0, 4, 1, 1, 0, 1, 0, 1, 0, 0);
    t[2] = mk(1, 1, 4, 1, 0, 0, 4, 1, 1, 0, 2, 0, 0, 0, 1);
    t[3] = mk(0, 1, 4, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (t[i]) begin
      apply(t[i]);
      vectors++;
      if ({fwd_sel_a, fwd_sel_b, stall, inst_kill, stall_cycles} !== {t[i].ea, t[i].eb, t[i].es, t[i].ek, t[i].esc}) begin
        miscompares++;
        $display("FAIL reset_mid row %0d: got %s, expected %s", i, got_str(), exp_str(t[i]));
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(99) == 0);
      issue_valid = ($urandom_range(9) != 0);
      rs1 = 5'($urandom_range(3)); rs1_used = 1'($urandom_range(1));
      rs2 = 5'($urandom_range(3)); rs2_used = 1'($urandom_range(1));
      rd  = 5'($urandom_range(3)); rd_we = ($urandom_range(3) != 0);
      is_load   = 1'($urandom_range(1));
      flush_req = ($urandom_range(9) == 0);
      @(negedge clk);
      model_eval();
      ea = 2'(m_sel_a);
      eb = 2'(m_sel_b);
      vectors++;
      if ({fwd_sel_a, fwd_sel_b, stall, inst_kill, stall_cycles} !== {ea, eb, m_stall, m_kill, 16'(m_cnt)}) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %s, expected a=%0d b=%0d stall=%b kill=%b sc=%0d",
                 i, got_str(), ea, eb, m_stall, m_kill, m_cnt);
      end
      advance();
    end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    int  exp_cnt = 0;
    int  bad = 0;
    bit  exp_st;
    logic [15:0] exp_sc;
    do_reset();
    s_issue_valid = 1'b1; s_rs1 = 5'd7; s_rs1_used = 1'b1; s_rs2 = 5'd0; s_rs2_used = 1'b0;
    s_rd = 5'd7; s_rd_we = 1'b1; s_is_load = 1'b1; s_flush_req = 1'b0;
    for (int i = 0; i < 79000; i++) begin
      @(negedge clk);
      exp_st = (i % 6) != 0;
      exp_sc = (exp_cnt > 65535) ? 16'hFFFF : 16'(exp_cnt);
      if (s_stall !== exp_st || s_stall_cycles !== exp_sc) begin
        if (bad == 0) $display("note: first saturation deviation at cycle %0d: stall=%b sc=%0d, expected stall=%b sc=%0d",
                               i, s_stall, s_stall_cycles, exp_st, exp_sc);
        bad++;
      end
      if (exp_st) exp_cnt++;
      advance();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL saturation_pattern: %0d cycles deviated, expected 0", bad);
    end
    vectors++;
    if (s_stall_cycles !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL saturation_final: stall_cycles=%h, expected FFFF", s_stall_cycles);
    end
  endtask

  initial begin
    reset = 1'b1; rs1 = '0; rs2 = '0; rd = '0; rs1_used = 0; rs2_used = 0;
    rd_we = 0; is_load = 0; issue_valid = 0; flush_req = 0;
    s_rs1 = '0; s_rs2 = '0; s_rd = '0; s_rs1_used = 0; s_rs2_used = 0;
    s_rd_we = 0; s_is_load = 0; s_issue_valid = 0; s_flush_req = 0;
    model_clear();
    test_reset();
    test_forward();
    test_load_use();
    test_youngest_x0();
    test_kill();
    test_stall_vs_kill();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
